clk_period_meter: RTL and testbench

Measures the period of a slow clock-like signal, such as a divided clock from the lab's clock divider, in cycles of the fast system clock.
- On a start pulse it synchronizes sig_in, waits for a rising edge, and counts clk cycles until the next rising edge.
- It then presents the count with a sticky valid flag.
- It is the receiving end of the divided-clock interface, used to check divider ratios on hardware and in simulation.

---
 rtl/clk_period_meter.sv | 116 +++++++++++
 tb/tb_clk_period_meter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous signal in clk cycles, rising edge to rising edge.
// A watchdog abandons the measurement after TIMEOUT cycles; results stay sticky until the next start.
module clk_period_meter #(
  parameter int CNT_W       = 27,
  parameter int TIMEOUT     = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             terr_q, terr_d;

  // History flop runs in every state so a level already high at start never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    period_d = period_q;
    valid_d  = valid_q;
    terr_d   = terr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          valid_d = 1'b0;
          terr_d  = 1'b0;
          wd_d    = '0;
        end
      end
      S_ARM: begin
        wd_d = wd_q + ONE;
        if (wd_q == WD_LAST) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end else if (rise) begin
          state_d = S_MEAS;
          cnt_d   = ONE;
        end
      end
      S_MEAS: begin
        wd_d = wd_q + ONE;
        // A completing edge on the last watchdog cycle still counts as a good measurement.
        if (rise) begin
          state_d  = S_IDLE;
          period_d = cnt_q;
          valid_d  = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wd_q     <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
    end
  end

  assign period      = period_q;
  assign valid       = valid_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q == S_ARM) || (state_q == S_MEAS);

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: table of duty/period patterns plus hand-written
// sequences for timeout, ignored starts, pre-high input and asynchronous reset.
module tb_clk_period_meter;

  localparam int CNT_W   = 27;
  localparam int TIMEOUT = 100;
  localparam int SYNC    = 2;

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic             start;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             busy;
  logic             timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  bit gen_en    = 1'b0;
  bit gen_level = 1'b0;
  int hi_len    = 4;
  int lo_len    = 4;
  int gen_cnt   = 0;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .start      (start),
    .period     (period),
    .valid      (valid),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern generator: high for hi_len cycles, low for lo_len cycles, changes on negedge.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_en) begin
        gen_cnt++;
        if (sig_in && gen_cnt >= hi_len) begin
          sig_in  = 1'b0;
          gen_cnt = 0;
        end else if (!sig_in && gen_cnt >= lo_len) begin
          sig_in  = 1'b1;
          gen_cnt = 0;
        end
      end else begin
        sig_in  = gen_level;
        gen_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic run_pattern(input int hi, input int lo);
    hi_len = hi;
    lo_len = lo;
    gen_en = 1'b1;
    repeat (2 * (hi + lo) + 4) @(negedge clk);
  endtask

  task automatic do_start(input string name);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_lat"}, longint'(busy), 1);
  endtask

  // Counts negedges with busy high (the one seen by do_start included).
  task automatic wait_done(input string name, input int max, output int cycles);
    cycles = busy ? 1 : 0;
    for (int i = 0; i < max && busy; i++) begin
      @(negedge clk);
      if (busy) cycles++;
    end
    check({name, "_done"}, longint'(busy), 0);
  endtask

  typedef struct {
    int hi;
    int lo;
    bit exp_valid;
    bit exp_terr;
    int exp_period;
  } vec_t;

  vec_t vecs[6];
  int   cyc;

  initial begin
    vecs[0] = '{hi: 4,  lo: 4,  exp_valid: 1'b1, exp_terr: 1'b0, exp_period: 8};
    vecs[1] = '{hi: 3,  lo: 10, exp_valid: 1'b1, exp_terr: 1'b0, exp_period: 13};
    vecs[2] = '{hi: 12, lo: 1,  exp_valid: 1'b1, exp_terr: 1'b0, exp_period: 13};
    vecs[3] = '{hi: 1,  lo: 1,  exp_valid: 1'b1, exp_terr: 1'b0, exp_period: 2};
    vecs[4] = '{hi: 20, lo: 20, exp_valid: 1'b1, exp_terr: 1'b0, exp_period: 40};
    vecs[5] = '{hi: 60, lo: 60, exp_valid: 1'b0, exp_terr: 1'b1, exp_period: 40};

    rst   = 1'b1;
    start = 1'b0;
    #1;
    check("rst_period", longint'(period), 0);
    check("rst_valid", longint'(valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_terr", longint'(timeout_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_rst_busy", longint'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_pattern(vecs[i].hi, vecs[i].lo);
      do_start($sformatf("vec%0d", i));
      wait_done($sformatf("vec%0d", i), 300, cyc);
      check($sformatf("vec%0d_valid", i), longint'(valid), longint'(vecs[i].exp_valid));
      check($sformatf("vec%0d_terr", i), longint'(timeout_err), longint'(vecs[i].exp_terr));
      check($sformatf("vec%0d_period", i), longint'(period), longint'(vecs[i].exp_period));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_lat_in_bound", i),
              longint'(cyc <= 2 * vecs[i].exp_period + SYNC + 2), 1);
      else
        check($sformatf("vec%0d_timeout_cycles", i), longint'(cyc), TIMEOUT);
    end

    // Fresh 8-cycle result, then a stuck-low timeout must keep it.
    run_pattern(4, 4);
    do_start("base8");
    wait_done("base8", 300, cyc);
    check("base8_period", longint'(period), 8);
    gen_en    = 1'b0;
    gen_level = 1'b0;
    repeat (5) @(negedge clk);
    do_start("tmo");
    wait_done("tmo", 300, cyc);
    check("tmo_busy_cycles", longint'(cyc), TIMEOUT);
    check("tmo_terr", longint'(timeout_err), 1);
    check("tmo_valid", longint'(valid), 0);
    check("tmo_period_kept", longint'(period), 8);

    // Second start mid-measurement is ignored; start in IDLE clears valid.
    run_pattern(4, 4);
    do_start("ign");
    repeat (6) @(negedge clk);
    check("ign_still_busy", longint'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", 300, cyc);
    check("ign_valid", longint'(valid), 1);
    check("ign_period", longint'(period), 8);
    check("ign_not_extended", longint'(cyc <= 2 * 8 + SYNC + 2), 1);
    do_start("restart");
    check("restart_valid_clr", longint'(valid), 0);
    check("restart_terr_clr", longint'(timeout_err), 0);
    wait_done("restart", 300, cyc);
    check("restart_period", longint'(period), 8);

    // Input already high when armed: first counted edge is the next 0->1.
    gen_en    = 1'b0;
    gen_level = 1'b1;
    repeat (10) @(negedge clk);
    do_start("prehigh");
    repeat (5) @(negedge clk);
    check("prehigh_armed", longint'(busy), 1);
    check("prehigh_no_valid", longint'(valid), 0);
    hi_len = 5;
    lo_len = 5;
    gen_en = 1'b1;
    wait_done("prehigh", 300, cyc);
    check("prehigh_valid", longint'(valid), 1);
    check("prehigh_period", longint'(period), 10);

    // Asynchronous reset with a completed result showing.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", longint'(valid), 0);
    check("arst_period", longint'(period), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-measurement: nothing stale may be captured afterwards.
    run_pattern(4, 4);
    do_start("mrst");
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", longint'(busy), 0);
    check("mrst_valid", longint'(valid), 0);
    check("mrst_period", longint'(period), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("mrst_post_busy", longint'(busy), 0);
    check("mrst_post_valid", longint'(valid), 0);
    check("mrst_post_period", longint'(period), 0);

    do_start("resume");
    wait_done("resume", 300, cyc);
    check("resume_valid", longint'(valid), 1);
    check("resume_period", longint'(period), 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
